instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage sitting between the program counter and the accumulator/decode path.
//  Holds its own fetch pointer, which is redirected by jump/jump_addr exactly like the PC.
//  Issues single-outstanding reads to instruction memory over a valid/ready request channel.
//  Buffers returned words with their addresses in a DEPTH-entry FIFO and presents them
//  downstream over a valid/ready handshake.
// PARAMETERS
//  ADDR_W  16  fetch address width
//  DATA_W  16  instruction word width
//  DEPTH   2   instruction buffer entries (power of 2, >=2)
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       asynchronous, active-low reset
//  jump           in   1       redirect request; sampled on clk
//  jump_addr      in   ADDR_W  redirect target
//  mem_req_valid  out  1       read request valid
//  mem_req_addr   out  ADDR_W  read address
//  mem_req_ready  in   1       memory accepts request this cycle
//  mem_rsp_valid  in   1       read data valid (one per accepted request)
//  mem_rsp_data   in   DATA_W  read data
//  instr_valid    out  1       buffer head valid
//  instr          out  DATA_W  buffer head instruction
//  instr_pc       out  ADDR_W  address of buffer head instruction
//  instr_ready    in   1       consumer pops head when instr_valid && instr_ready
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state=IDLE, fetch_addr=0, buffer empty, drop flag=0
//   - all outputs 0
//  FSM:
//   - IDLE -> REQ on first clk after reset release
//   - REQ: mem_req_valid=1, mem_req_addr=fetch_addr; only entered when buffer has space
//   - REQ -> WAIT on accept (valid&&ready); fetch_addr <= fetch_addr+1, wraps 0xFFFF->0x0000
//   - WAIT -> REQ on mem_rsp_valid if (count after this edge) < DEPTH
//   - WAIT -> HOLD on mem_rsp_valid otherwise
//   - HOLD -> REQ once a pop frees an entry
//  Request channel:
//   - mem_req_addr is stable while mem_req_valid && !mem_req_ready, except on jump (see below)
//   - At most one request outstanding; mem_rsp_valid outside WAIT is ignored
//  Buffer:
//   - Response pushes {fetch addr of that request, mem_rsp_data}
//   - Push and pop in the same cycle: both occur, count unchanged
//   - instr_valid = (count != 0); instr/instr_pc are the head entry; min latency rsp->instr_valid = 1 clk
//   - Pop when empty is impossible (instr_valid=0); a push never arrives when full (space gated in REQ)
//  Jump (jump=1 at clk edge):
//   - Buffer flushed (count=0); any same-cycle pop or push discarded
//   - fetch_addr <= jump_addr; state -> REQ; next request addresses jump_addr
//   - From REQ, the pending unaccepted request is withdrawn; an accept in the same cycle is treated as
//     outstanding and dropped
//   - From WAIT, drop flag set; the outstanding response is discarded; new request issues only after it
//     arrives (state stays WAIT with drop=1, then -> REQ)
//   - Jump coincident with the awaited response: response discarded, state -> REQ
//  Reset mid-operation: immediate return to reset values; outstanding memory response is not tracked.
// TESTING
//  T1 reset release, memory ready=1, 1-cycle rsp returning addr^16'hA5A5 -> instr_pc 0,1,2... in order,
//     instr=addr^A5A5
//  T2 instr_ready=0 -> exactly DEPTH(2) entries buffered, mem_req_valid stays 0; assert ready -> resumes
//     at addr 2
//  T3 mem_req_ready=0 for 5 cycles -> mem_req_valid=1, addr held constant; accept on cycle 6
//  T4 jump=1, jump_addr=16'h5678 during WAIT -> stale rsp dropped, next request addr 5678, first
//     instr_pc=5678
//  T5 fetch_addr=16'hFFFF -> instr_pc sequence FFFF, 0000, 0001
//  T6 reset=0 pulse mid-WAIT -> all outputs 0 asynchronously; fetch restarts at 0000

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: single-outstanding memory reads, DEPTH-entry {pc, instr} buffer,
// and redirect on jump with discard of any stale in-flight response.
module instr_fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t                         r_state;
    logic [ADDR_W-1:0]              r_fetch_addr;
    logic [ADDR_W-1:0]              r_out_addr;
    logic                           r_drop;
    logic [DEPTH-1:0][ADDR_W-1:0]   r_buf_pc;
    logic [DEPTH-1:0][DATA_W-1:0]   r_buf_data;
    logic [PW-1:0]                  r_wptr;
    logic [PW-1:0]                  r_rptr;
    logic [CW-1:0]                  r_count;

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;
    logic          w_space;

    assign w_accept    = (r_state == REQ) && mem_req_ready;
    // A redirect overrides both buffer operations in its cycle.
    assign w_push      = (r_state == WAIT) && mem_rsp_valid && !r_drop && !jump;
    assign w_pop       = instr_valid && instr_ready && !jump;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_space     = w_count_nxt < CW'(DEPTH);

    assign mem_req_valid = (r_state == REQ);
    assign mem_req_addr  = r_fetch_addr;
    assign instr_valid   = (r_count != '0);
    assign instr         = r_buf_data[r_rptr];
    assign instr_pc      = r_buf_pc[r_rptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_fetch_addr <= '0;
            r_out_addr   <= '0;
            r_drop       <= 1'b0;
            r_buf_pc     <= '0;
            r_buf_data   <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
        end else if (jump) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_fetch_addr <= jump_addr;
            case (r_state)
                // An accept racing the jump is still in flight; its response must be swallowed.
                REQ: begin
                    r_state <= mem_req_ready ? WAIT : REQ;
                    r_drop  <= mem_req_ready;
                end
                WAIT: begin
                    r_state <= mem_rsp_valid ? REQ : WAIT;
                    r_drop  <= !mem_rsp_valid;
                end
                default: begin
                    r_state <= REQ;
                    r_drop  <= 1'b0;
                end
            endcase
        end else begin
            if (w_push) begin
                r_buf_pc[r_wptr]   <= r_out_addr;
                r_buf_data[r_wptr] <= mem_rsp_data;
                r_wptr             <= r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            case (r_state)
                IDLE: r_state <= REQ;
                REQ: begin
                    if (w_accept) begin
                        r_out_addr   <= r_fetch_addr;
                        r_fetch_addr <= r_fetch_addr + 1'b1;
                        r_state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        r_drop  <= 1'b0;
                        r_state <= w_space ? REQ : HOLD;
                    end
                end
                HOLD: begin
                    if (w_space)
                        r_state <= REQ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory model answers addr^A5A5, a monitor pops
// expected {pc, instr} pairs as the consumer takes them.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        jump = 1'b0;
    logic [15:0] jump_addr = '0;
    logic        mem_req_valid;
    logic [15:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid = 1'b0;
    logic [15:0] mem_rsp_data = '0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;

    logic        mem_rdy_en = 1'b1;
    logic [15:0] stop_addr = 16'h0004;
    int          rsp_lat = 1;
    logic        pend = 1'b0;
    int          pcnt = 0;
    logic [15:0] paddr = '0;

    int vecs = 0;
    int errs = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } exp_t;
    exp_t expq[$];

    instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .jump(jump), .jump_addr(jump_addr),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    // Memory refuses the request at stop_addr, which ends each directed stream at a known point.
    assign mem_req_ready = mem_rdy_en && (mem_req_addr != stop_addr);

    always begin
        @(posedge clk);
        if (!reset)
            pend = 1'b0;
        else if (mem_req_valid && mem_req_ready) begin
            pend  = 1'b1;
            pcnt  = rsp_lat;
            paddr = mem_req_addr;
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        if (pend && reset) begin
            pcnt--;
            if (pcnt <= 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = paddr ^ 16'hA5A5;
                pend          = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [15:0] pc);
        expq.push_back('{pc: pc, data: pc ^ 16'hA5A5});
    endtask

    task automatic wait_req(input string nm, input logic [15:0] a);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, 32'(mem_req_valid), 32'd1);
        chk({nm, "_addr"}, 32'(mem_req_addr), 32'(a));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({nm, "_req_addr"}, 32'(mem_req_addr), 32'd0);
        chk({nm, "_instr_valid"}, 32'(instr_valid), 32'd0);
        chk({nm, "_instr"}, 32'(instr), 32'd0);
        chk({nm, "_instr_pc"}, 32'(instr_pc), 32'd0);
    endtask

    // Monitor: compares the head whenever the consumer will pop it on the next edge.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (reset && instr_valid && instr_ready && !jump) begin
            if (expq.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_pop: got pc %h expected none", instr_pc);
            end else begin
                e = expq.pop_front();
                chk("instr_pc", 32'(instr_pc), 32'(e.pc));
                chk("instr", 32'(instr), 32'(e.data));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        for (int i = 0; i < 4; i++) expect_pc(16'(i));
        reset = 1'b1;

        // Consumer stalled: two entries buffered, fetch stops, then resumes at 2.
        repeat (12) @(negedge clk);
        chk("t2_hold_req_valid", 32'(mem_req_valid), 32'd0);
        chk("t2_hold_instr_valid", 32'(instr_valid), 32'd1);
        chk("t2_hold_head_pc", 32'(instr_pc), 32'd0);
        instr_ready = 1'b1;
        wait_req("t2_resume", 16'h0002);
        repeat (15) @(negedge clk);
        chk("t1_drained", 32'(expq.size()), 32'd0);

        // Memory back-pressure: address held for 5 cycles, accept on the 6th.
        mem_rdy_en = 1'b0;
        stop_addr  = 16'h0008;
        for (int i = 4; i < 8; i++) expect_pc(16'(i));
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_valid", 32'(mem_req_valid), 32'd1);
            chk("t3_stall_addr", 32'(mem_req_addr), 32'h0004);
            @(negedge clk);
        end
        mem_rdy_en = 1'b1;
        repeat (20) @(negedge clk);

        // Jump while waiting on a slow response: stale word dropped, no request until it lands.
        expect_pc(16'h5678);
        expect_pc(16'h5679);
        rsp_lat   = 4;
        stop_addr = 16'h567A;
        @(negedge clk);
        jump      = 1'b1;
        jump_addr = 16'h5678;
        @(negedge clk);
        jump    = 1'b0;
        rsp_lat = 1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_drop_wait", 32'(mem_req_valid), 32'd0);
            @(negedge clk);
        end
        wait_req("t4_redirect", 16'h5678);
        repeat (15) @(negedge clk);

        // Jump coinciding with an accept, then address wrap.
        jump      = 1'b1;
        jump_addr = 16'hFFFF;
        stop_addr = 16'h0002;
        expect_pc(16'hFFFF);
        expect_pc(16'h0000);
        expect_pc(16'h0001);
        @(negedge clk);
        jump = 1'b0;
        wait_req("t5_wrap", 16'hFFFF);
        repeat (15) @(negedge clk);

        // Asynchronous reset while a request is outstanding.
        rsp_lat   = 4;
        stop_addr = 16'h0003;
        @(negedge clk);
        #3 reset = 1'b0;
        #1 chk_zero("t6_async");
        rsp_lat = 1;
        for (int i = 0; i < 3; i++) expect_pc(16'(i));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_req("t6_restart", 16'h0000);
        repeat (15) @(negedge clk);
        chk("final_drained", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
